// File: rtl/decode_issue_unit_l2.sv
// decode_issue_unit_l2
//
// Purpose: second-generation decode/issue stage between fetch and a set of
// execute pipes. It holds one fetched instruction, decodes tinyrv1, reads
// a local 32-entry register file, and tracks in-flight writers in a
// per-register scoreboard (pending bit + owning ROB tag). It stalls on RAW
// hazards and when the ROB credit is exhausted. It issues at most one uop
// per cycle to the lowest-index ready pipe that supports the op. Register
// writes retire from the completion interface.
//
// Optional feature macro: DECODE_ISSUE_BYPASS_EN
//   defined   : a source whose owning completion arrives this cycle is taken
//               from C_wdata and does not stall.
//   undefined : the dependent issues the cycle after completion.
//
// Op-vector bit / uop encoding (rv_op_vec / rv_uop):
//   0 ADD, 1 ADDI, 2 MUL, 3 LW, 4 SW, 5 JAL, 6 JALR, 7 BNE
//
// Ports:
//   clk, rst (async, active-low)
//   F_val/F_rdy/F_inst/F_pc    fetch -> decode handshake
//   X_val/X_rdy [p_num_pipes]  per-pipe issue handshake
//   X_pc/X_op1/X_op2/X_waddr/X_uop/X_seq_num  issue payload (shared by all pipes)
//   C_val/C_seq_num/C_waddr/C_wdata/C_wen     completion notification
//   illegal                    pulses when an unsupported instruction is dropped
module decode_issue_unit_l2 #(
  parameter logic [7:0] p_isa_subset  = 8'hFF,
  parameter int         p_num_pipes   = 3,
  parameter int         p_addr_bits   = 32,
  parameter int         p_inst_bits   = 32,
  parameter int         p_data_bits   = 32,
  parameter int         p_rob_entries = 32,
  parameter logic [p_num_pipes-1:0][7:0] p_pipe_subsets = {p_num_pipes{8'hFF}}
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               F_val,
  output logic                                               F_rdy,
  input  logic [p_inst_bits-1:0]                             F_inst,
  input  logic [p_addr_bits-1:0]                             F_pc,
  output logic [p_num_pipes-1:0]                             X_val,
  input  logic [p_num_pipes-1:0]                             X_rdy,
  output logic [p_num_pipes-1:0][p_addr_bits-1:0]            X_pc,
  output logic [p_num_pipes-1:0][p_data_bits-1:0]            X_op1,
  output logic [p_num_pipes-1:0][p_data_bits-1:0]            X_op2,
  output logic [p_num_pipes-1:0][4:0]                        X_waddr,
  output logic [p_num_pipes-1:0][2:0]                        X_uop,
  output logic [p_num_pipes-1:0][$clog2(p_rob_entries)-1:0]  X_seq_num,
  input  logic                                               C_val,
  input  logic [$clog2(p_rob_entries)-1:0]                   C_seq_num,
  input  logic [4:0]                                         C_waddr,
  input  logic [p_data_bits-1:0]                             C_wdata,
  input  logic                                               C_wen,
  output logic                                               illegal
);

  localparam int SB = $clog2(p_rob_entries);
  localparam logic [SB:0] ROB_FULL = (SB+1)'(p_rob_entries);

  localparam logic [2:0] UOP_ADD  = 3'd0;
  localparam logic [2:0] UOP_ADDI = 3'd1;
  localparam logic [2:0] UOP_MUL  = 3'd2;
  localparam logic [2:0] UOP_LW   = 3'd3;
  localparam logic [2:0] UOP_SW   = 3'd4;
  localparam logic [2:0] UOP_JAL  = 3'd5;
  localparam logic [2:0] UOP_JALR = 3'd6;
  localparam logic [2:0] UOP_BNE  = 3'd7;

  logic                   dvalid;
  logic [p_inst_bits-1:0] dinst;
  logic [p_addr_bits-1:0] dpc;

  logic [p_data_bits-1:0] rf [32];
  logic [31:0]            pending;
  logic [SB-1:0]          owner [32];
  logic [SB-1:0]          seq_ctr;
  logic [SB:0]            in_flight;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd, rs1, rs2;
  logic [p_data_bits-1:0] imm_i, imm_j;

  assign opcode = dinst[6:0];
  assign rd     = dinst[11:7];
  assign funct3 = dinst[14:12];
  assign rs1    = dinst[19:15];
  assign rs2    = dinst[24:20];
  assign funct7 = dinst[31:25];
  assign imm_i  = {{(p_data_bits-12){dinst[31]}}, dinst[31:20]};
  assign imm_j  = {{(p_data_bits-21){dinst[31]}}, dinst[31], dinst[19:12],
                   dinst[20], dinst[30:21], 1'b0};

  logic                   known, use_rs1, use_rs2, op1_pc, has_rd;
  logic [2:0]             uop;
  logic [p_data_bits-1:0] imm;

  // Instruction decode. SW and BNE carry both register sources as operands;
  // their offsets are not forwarded by this stage.
  always_comb begin
    known   = 1'b1;
    uop     = UOP_ADD;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    op1_pc  = 1'b0;
    has_rd  = 1'b0;
    imm     = imm_i;
    case (opcode)
      7'b0110011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        has_rd  = 1'b1;
        if (funct3 == 3'b000 && funct7 == 7'b0000000)      uop = UOP_ADD;
        else if (funct3 == 3'b000 && funct7 == 7'b0000001) uop = UOP_MUL;
        else                                               known = 1'b0;
      end
      7'b0010011: begin
        uop = UOP_ADDI; use_rs1 = 1'b1; has_rd = 1'b1;
        known = (funct3 == 3'b000);
      end
      7'b0000011: begin
        uop = UOP_LW; use_rs1 = 1'b1; has_rd = 1'b1;
        known = (funct3 == 3'b010);
      end
      7'b0100011: begin
        uop = UOP_SW; use_rs1 = 1'b1; use_rs2 = 1'b1;
        known = (funct3 == 3'b010);
      end
      7'b1101111: begin
        uop = UOP_JAL; op1_pc = 1'b1; has_rd = 1'b1; imm = imm_j;
      end
      7'b1100111: begin
        uop = UOP_JALR; use_rs1 = 1'b1; has_rd = 1'b1;
        known = (funct3 == 3'b000);
      end
      7'b1100011: begin
        uop = UOP_BNE; use_rs1 = 1'b1; use_rs2 = 1'b1;
        known = (funct3 == 3'b001);
      end
      default: known = 1'b0;
    endcase
  end

  logic [4:0]             waddr;
  logic [p_data_bits-1:0] src1, src2, op1, op2;
  logic                   byp1, byp2;

  assign waddr = has_rd ? rd : 5'd0;

  // Operand read. x0 is never written, so rf[0] always reads zero.
  always_comb begin
    src1 = rf[rs1];
    src2 = rf[rs2];
    byp1 = 1'b0;
    byp2 = 1'b0;
`ifdef DECODE_ISSUE_BYPASS_EN
    if (C_val && C_wen && C_waddr == rs1 && rs1 != 5'd0 && pending[rs1] &&
        owner[rs1] == C_seq_num) begin
      byp1 = 1'b1;
      src1 = C_wdata;
    end
    if (C_val && C_wen && C_waddr == rs2 && rs2 != 5'd0 && pending[rs2] &&
        owner[rs2] == C_seq_num) begin
      byp2 = 1'b1;
      src2 = C_wdata;
    end
`endif
  end

  assign op1 = op1_pc  ? p_data_bits'(dpc) : src1;
  assign op2 = use_rs2 ? src2 : imm;

  logic [p_num_pipes-1:0] sup, sel;
  logic legal, hazard, stall, drop, issue_fire, c_write;

  assign hazard = (use_rs1 && rs1 != 5'd0 && pending[rs1] && !byp1) ||
                  (use_rs2 && rs2 != 5'd0 && pending[rs2] && !byp2);
  assign stall  = hazard || (in_flight == ROB_FULL);

  // Pick the lowest-index pipe that both supports the op and is ready.
  // Lower pipes' ready inherently gates higher pipes' valid here.
  always_comb begin
    sel = '0;
    for (int j = 0; j < p_num_pipes; j++) begin
      sup[j] = p_pipe_subsets[j][uop];
      if (sel == '0 && sup[j] && X_rdy[j]) sel[j] = 1'b1;
    end
  end

  assign legal      = known && p_isa_subset[uop] && (|sup);
  assign drop       = dvalid && !legal;
  assign X_val      = sel & {p_num_pipes{dvalid && legal && !stall}};
  assign issue_fire = |(X_val & X_rdy);
  assign illegal    = drop;
  assign F_rdy      = rst && (!dvalid || issue_fire || drop);

  assign X_pc      = {p_num_pipes{dpc}};
  assign X_op1     = {p_num_pipes{op1}};
  assign X_op2     = {p_num_pipes{op2}};
  assign X_waddr   = {p_num_pipes{waddr}};
  assign X_uop     = {p_num_pipes{uop}};
  assign X_seq_num = {p_num_pipes{seq_ctr}};

  // Single-entry decode register; a dropped illegal op frees it just like an issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dvalid <= 1'b0;
      dinst  <= '0;
      dpc    <= '0;
    end else if (F_val && F_rdy) begin
      dvalid <= 1'b1;
      dinst  <= F_inst;
      dpc    <= F_pc;
    end else if (issue_fire || drop) begin
      dvalid <= 1'b0;
    end
  end

  // Only the current owner of a register may retire into it; stale completions are ignored.
  assign c_write = C_val && C_wen && C_waddr != 5'd0 && pending[C_waddr] &&
                   owner[C_waddr] == C_seq_num;

  // Register file, scoreboard and ROB credit. The issue update comes last
  // so a same-cycle new writer keeps the register pending under its own tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending   <= '0;
      seq_ctr   <= '0;
      in_flight <= '0;
      for (int i = 0; i < 32; i++) begin
        rf[i]    <= '0;
        owner[i] <= '0;
      end
    end else begin
      if (c_write) begin
        rf[C_waddr]      <= C_wdata;
        pending[C_waddr] <= 1'b0;
      end
      if (issue_fire) begin
        seq_ctr <= seq_ctr + 1'b1;
        if (waddr != 5'd0) begin
          pending[waddr] <= 1'b1;
          owner[waddr]   <= seq_ctr;
        end
      end
      if (issue_fire && !C_val)      in_flight <= in_flight + 1'b1;
      else if (!issue_fire && C_val) in_flight <= in_flight - 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_issue_unit_l2.sv
// tb_decode_issue_unit_l2
//
// Scoreboard bench for decode_issue_unit_l2 configured with 3 pipes
// (pipe0 full tinyrv1, pipe1 ADD only, pipe2 full) and an 8-entry ROB.
// Stimulus pushes the hand-computed issue it expects; a monitor pops and
// compares whenever a pipe handshake fires.
module tb_decode_issue_unit_l2;

  localparam int NP = 3;
  localparam int SB = 3;
  localparam logic [2:0] U_ADD = 3'd0, U_ADDI = 3'd1, U_MUL = 3'd2, U_JAL = 3'd5;
`ifdef DECODE_ISSUE_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic F_val = 1'b0;
  logic F_rdy;
  logic [31:0] F_inst = '0;
  logic [31:0] F_pc = '0;
  logic [NP-1:0] X_val;
  logic [NP-1:0] X_rdy = '0;
  logic [NP-1:0][31:0] X_pc, X_op1, X_op2;
  logic [NP-1:0][4:0] X_waddr;
  logic [NP-1:0][2:0] X_uop;
  logic [NP-1:0][SB-1:0] X_seq_num;
  logic C_val = 1'b0;
  logic [SB-1:0] C_seq_num = '0;
  logic [4:0] C_waddr = '0;
  logic [31:0] C_wdata = '0;
  logic C_wen = 1'b0;
  logic illegal;

  decode_issue_unit_l2 #(
    .p_num_pipes(NP),
    .p_rob_entries(8),
    .p_pipe_subsets({8'hFF, 8'h01, 8'hFF})
  ) dut (
    .clk(clk), .rst(rst),
    .F_val(F_val), .F_rdy(F_rdy), .F_inst(F_inst), .F_pc(F_pc),
    .X_val(X_val), .X_rdy(X_rdy), .X_pc(X_pc), .X_op1(X_op1), .X_op2(X_op2),
    .X_waddr(X_waddr), .X_uop(X_uop), .X_seq_num(X_seq_num),
    .C_val(C_val), .C_seq_num(C_seq_num), .C_waddr(C_waddr), .C_wdata(C_wdata),
    .C_wen(C_wen), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          pipe;
    logic [31:0] pc;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  waddr;
    logic [2:0]  uop;
    logic [2:0]  seq;
    int          cyc;
  } exp_t;

  exp_t expq[$];
  int n_vec = 0;
  int n_mis = 0;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pushExp(input int pipe, input logic [31:0] pc, input logic [31:0] op1,
                         input logic [31:0] op2, input logic [4:0] waddr,
                         input logic [2:0] uop, input logic [2:0] seq, input int c);
    exp_t e;
    e.pipe = pipe; e.pc = pc; e.op1 = op1; e.op2 = op2;
    e.waddr = waddr; e.uop = uop; e.seq = seq; e.cyc = c;
    expq.push_back(e);
  endtask

  // Presents one fetch message; returns the cycle in which it sits in decode.
  task automatic applyStimulus(input logic [31:0] inst, input logic [31:0] pc, output int acc);
    F_val = 1'b1;
    F_inst = inst;
    F_pc = pc;
    acc = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (F_rdy) begin
        @(posedge clk);
        #1;
        acc = cyc;
        break;
      end
    end
    F_val = 1'b0;
    if (acc < 0) begin
      n_vec++;
      n_mis++;
      $display("[TB] FAIL fetch_timeout: pc 0x%0h never accepted, required accept within 50 cycles", pc);
    end
  endtask

  task automatic complete(input logic [2:0] seq, input logic [4:0] waddr, input logic [31:0] wdata);
    C_val = 1'b1;
    C_wen = 1'b1;
    C_seq_num = seq;
    C_waddr = waddr;
    C_wdata = wdata;
    @(posedge clk);
    #1;
    C_val = 1'b0;
    C_wen = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkStalled(input string name);
    @(negedge clk);
    checkOutput({name, "_xval"}, 32'(X_val), 32'd0);
    checkOutput({name, "_frdy"}, 32'(F_rdy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every fired pipe handshake must match the head of the queue.
  exp_t mon_e;
  logic mon_bad;
  always @(negedge clk) begin
    if (rst) begin
      if (X_val != '0) checkOutput("xval_onehot", 32'($countones(X_val)), 32'd1);
      for (int j = 0; j < NP; j++) begin
        if (X_val[j] && X_rdy[j]) begin
          n_vec++;
          if (expq.size() == 0) begin
            n_mis++;
            $display("[TB] FAIL unexpected_issue: pipe %0d pc 0x%0h seq %0d at cycle %0d, required no issue",
                     j, X_pc[j], X_seq_num[j], cyc);
          end else begin
            mon_e = expq.pop_front();
            mon_bad = (j != mon_e.pipe) || (X_pc[j] !== mon_e.pc) ||
                      (X_op1[j] !== mon_e.op1) || (X_op2[j] !== mon_e.op2) ||
                      (X_waddr[j] !== mon_e.waddr) || (X_uop[j] !== mon_e.uop) ||
                      (X_seq_num[j] !== mon_e.seq) || (mon_e.cyc >= 0 && cyc != mon_e.cyc);
            if (mon_bad) begin
              n_mis++;
              $display("[TB] FAIL issue_pc_%0h: got pipe %0d op1 0x%0h op2 0x%0h waddr %0d uop %0d seq %0d cyc %0d; expected pipe %0d op1 0x%0h op2 0x%0h waddr %0d uop %0d seq %0d cyc %0d",
                       mon_e.pc, j, X_op1[j], X_op2[j], X_waddr[j], X_uop[j], X_seq_num[j], cyc,
                       mon_e.pipe, mon_e.op1, mon_e.op2, mon_e.waddr, mon_e.uop, mon_e.seq, mon_e.cyc);
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a0, a1, a2, acc, c;

    // Reset state
    #12;
    checkOutput("reset_frdy", 32'(F_rdy), 32'd0);
    checkOutput("reset_xval", 32'(X_val), 32'd0);
    checkOutput("reset_illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    waitCycles(1);
    checkOutput("post_reset_frdy", 32'(F_rdy), 32'd1);

    // Back-to-back ADDIs, 1-cycle latency, seq 0,1,2
    X_rdy = 3'b111;
    applyStimulus(32'h0050_0093, 32'h0, a0);          // ADDI x1,x0,5
    pushExp(0, 32'h0, 32'd0, 32'd5, 5'd1, U_ADDI, 3'd0, a0);
    applyStimulus(enc_addi(5'd2, 5'd0, 12'd6), 32'h4, a1);
    pushExp(0, 32'h4, 32'd0, 32'd6, 5'd2, U_ADDI, 3'd1, a1);
    applyStimulus(enc_addi(5'd3, 5'd0, 12'hFFF), 32'h8, a2);
    pushExp(0, 32'h8, 32'd0, 32'hFFFF_FFFF, 5'd3, U_ADDI, 3'd2, a2);
    checkOutput("back_to_back", 32'(a2 - a0), 32'd2);
    waitCycles(1);
    complete(3'd0, 5'd1, 32'd5);
    complete(3'd1, 5'd2, 32'd6);
    complete(3'd2, 5'd3, 32'hFFFF_FFFF);

    // RAW stall on x4, released by completion of seq3
    applyStimulus(enc_addi(5'd4, 5'd0, 12'd7), 32'h10, acc);
    pushExp(0, 32'h10, 32'd0, 32'd7, 5'd4, U_ADDI, 3'd3, acc);
    applyStimulus(enc_r(7'd0, 5'd5, 5'd4, 5'd4), 32'h14, acc);
    checkStalled("raw_stall0");
    checkStalled("raw_stall1");
    c = cyc;
    pushExp(0, 32'h14, 32'd7, 32'd7, 5'd5, U_ADD, 3'd4, c + 1 - BYP);
    complete(3'd3, 5'd4, 32'd7);
    waitCycles(2);
    complete(3'd4, 5'd5, 32'd14);

    // Pipe subsets: ADD goes to pipe1, MUL waits for pipe0
    X_rdy = 3'b010;
    applyStimulus(enc_r(7'd0, 5'd6, 5'd1, 5'd2), 32'h18, acc);
    pushExp(1, 32'h18, 32'd5, 32'd6, 5'd6, U_ADD, 3'd5, acc);
    applyStimulus(enc_r(7'd1, 5'd7, 5'd1, 5'd2), 32'h1C, acc);
    checkStalled("mul_wait0");
    checkStalled("mul_wait1");
    pushExp(0, 32'h1C, 32'd5, 32'd6, 5'd7, U_MUL, 3'd6, cyc);
    X_rdy = 3'b011;
    waitCycles(1);
    X_rdy = 3'b111;
    complete(3'd5, 5'd6, 32'd11);
    complete(3'd6, 5'd7, 32'd30);

    // ROB credit: 8 in flight, 9th stalls, completion frees it with seq wrap to 0
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    waitCycles(1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(enc_addi(5'(8 + i), 5'd0, 12'(i)), 32'(32'h40 + 4 * i), acc);
      pushExp(0, 32'(32'h40 + 4 * i), 32'd0, 32'(i), 5'(8 + i), U_ADDI, 3'(i), acc);
    end
    applyStimulus(enc_addi(5'd16, 5'd0, 12'd100), 32'h60, acc);
    checkStalled("credit_stall0");
    checkStalled("credit_stall1");
    c = cyc;
    pushExp(0, 32'h60, 32'd0, 32'd100, 5'd16, U_ADDI, 3'd0, c + 1);
    complete(3'd0, 5'd8, 32'd0);
    waitCycles(1);
    for (int i = 1; i < 8; i++) complete(3'(i), 5'(8 + i), 32'(i));
    complete(3'd0, 5'd16, 32'd100);

    // WAW: stale completion of seq1 ignored, x3 stays pending until seq2
    applyStimulus(enc_addi(5'd3, 5'd0, 12'd1), 32'h80, acc);
    pushExp(0, 32'h80, 32'd0, 32'd1, 5'd3, U_ADDI, 3'd1, acc);
    applyStimulus(enc_addi(5'd3, 5'd0, 12'd2), 32'h84, acc);
    pushExp(0, 32'h84, 32'd0, 32'd2, 5'd3, U_ADDI, 3'd2, acc);
    waitCycles(1);
    complete(3'd1, 5'd3, 32'd7);
    applyStimulus(enc_r(7'd0, 5'd20, 5'd3, 5'd0), 32'h88, acc);
    checkStalled("waw_stall0");
    checkStalled("waw_stall1");
    c = cyc;
    pushExp(0, 32'h88, 32'd9, 32'd0, 5'd20, U_ADD, 3'd3, c + 1 - BYP);
    complete(3'd2, 5'd3, 32'd9);
    waitCycles(2);
    complete(3'd3, 5'd20, 32'd9);

    // Illegal encoding: one-cycle pulse, no issue, no seq consumed
    applyStimulus(32'hFFFF_FFFF, 32'h90, acc);
    @(negedge clk);
    checkOutput("illegal_pulse", 32'(illegal), 32'd1);
    checkOutput("illegal_no_issue", 32'(X_val), 32'd0);
    @(negedge clk);
    checkOutput("illegal_one_cycle", 32'(illegal), 32'd0);
    waitCycles(1);
    applyStimulus(enc_addi(5'd21, 5'd0, 12'd3), 32'h94, acc);
    pushExp(0, 32'h94, 32'd0, 32'd3, 5'd21, U_ADDI, 3'd4, acc);
    applyStimulus(enc_jal(5'd1, 21'd8), 32'h98, acc);
    pushExp(0, 32'h98, 32'h98, 32'd8, 5'd1, U_JAL, 3'd5, acc);

    // Async reset mid-stall: outputs drop at once, held instruction discarded
    applyStimulus(enc_r(7'd0, 5'd23, 5'd1, 5'd0), 32'h9C, acc);
    checkStalled("pre_reset_stall");
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_reset_xval", 32'(X_val), 32'd0);
    checkOutput("async_reset_frdy", 32'(F_rdy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    waitCycles(3);

    // Async reset while an issue is being presented
    applyStimulus(enc_addi(5'd24, 5'd0, 12'd1), 32'hA0, acc);
    checkOutput("pre_reset_xval", 32'(X_val), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("async_reset_xval_live", 32'(X_val), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    waitCycles(3);

    checkOutput("queue_empty", 32'(expq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
